word_pack_ctrl: RTL and testbench

//  Parametrised controller for the FIFO -> accumulator -> RAM packing path.
//  - Pops bytes from the input FIFO and steers the external byte accumulator.
//  - Packs BYTES_PER_WORD bytes per word and writes each word to RAM at an

---
 rtl/word_pack_pkg.sv | 28 ++
 rtl/word_pack_ctrl_mod_counter.sv | 34 +++
 rtl/word_pack_ctrl.sv | 122 ++++++++++++
 tb/tb_word_pack_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_pack_pkg.sv
// Shared types for the FIFO -> accumulator -> RAM word packer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package word_pack_pkg;

    // Stage records are sized for the widest legal configuration:
    // up to 16 bytes per word and up to 64K RAM words.
    localparam int MAX_BSEL_W = 4;
    localparam int MAX_ADDR_W = 16;

    typedef enum logic {
        RUN  = 1'b0,
        FULL = 1'b1
    } state_t;

    typedef struct packed {
        logic                  acc_en;
        logic [MAX_BSEL_W-1:0] byte_sel;
        logic                  close;
        logic [MAX_ADDR_W-1:0] addr;
    } stage_t;

    // Index width for a counter/selector over n values, never below one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/word_pack_ctrl_mod_counter.sv
// Modulo-MOD up-counter with synchronous clear and a terminal-count wrap flag.
// Latency: count updates on the edge after inc/clr; wrap is combinational.
// Backpressure: none; inc is honoured every cycle it is high.
module mod_counter
    import word_pack_pkg::*;
#(
    parameter int  MOD   = 4,
    localparam int CNT_W = idx_width(MOD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    logic at_max;

    assign at_max = (count == CNT_W'(MOD - 1));
    assign wrap   = inc & at_max;

    // Count register: clear beats increment, rolls over to 0 after MOD-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= at_max ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/word_pack_ctrl.sv
// Pops FIFO bytes, steers the byte accumulator and writes packed words to RAM.
// Latency: acc_en one cycle after the pop, write_ram two cycles after the word closes.
// Backpressure: pops only while the FIFO is non-empty; stalls in FULL until clear.
module word_pack_ctrl
    import word_pack_pkg::*;
#(
    parameter int  BYTES_PER_WORD = 4,
    parameter int  RAM_DEPTH      = 256,
    parameter int  WRAP           = 1,
    localparam int BSEL_W         = idx_width(BYTES_PER_WORD),
    localparam int ADDR_W         = idx_width(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic              flush,
    input  logic              clear,
    output logic              read,
    output logic              acc_en,
    output logic              zero_sel,
    output logic [BSEL_W-1:0] byte_sel,
    output logic              write_ram,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_full
);

    state_t              state_q;
    state_t              state_d;
    logic [BSEL_W-1:0]   byte_cnt;
    logic [ADDR_W-1:0]   issue_addr;
    logic                byte_wrap;
    logic                addr_wrap;
    logic                flush_ok;
    logic                word_close;
    stage_t              stage1_d;
    stage_t              stage1;
    stage_t              stage2;
    logic                unused_stage_bits;

    // Lane counter: a flush starts the next word at lane 0.
    mod_counter #(.MOD(BYTES_PER_WORD)) u_byte_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear | flush_ok),
        .inc   (read),
        .count (byte_cnt),
        .wrap  (byte_wrap)
    );

    // Word address counter: its wrap flag marks the last RAM slot being issued.
    mod_counter #(.MOD(RAM_DEPTH)) u_issue_addr (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (word_close),
        .count (issue_addr),
        .wrap  (addr_wrap)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, pop strobe, flush qualification and word-close decode.
    always_comb begin
        state_d    = state_q;
        read       = 1'b0;
        flush_ok   = 1'b0;
        word_close = 1'b0;
        if (state_q == RUN) begin
            // Flush and clear both block the pop, so a pop never meets a flush.
            read     = ~reset & ~fifo_empty & ~flush & ~clear;
            flush_ok = flush & ~clear & (byte_cnt != '0);
        end
        word_close = byte_wrap | flush_ok;
        if (addr_wrap && (WRAP == 0)) begin
            state_d = FULL;
        end
        if (clear) begin
            state_d = RUN;
        end
    end

    // Stage-1 record built from this cycle's pop/close decisions.
    always_comb begin
        stage1_d          = '0;
        stage1_d.acc_en   = read;
        stage1_d.byte_sel = MAX_BSEL_W'(byte_cnt);
        stage1_d.close    = word_close;
        stage1_d.addr     = MAX_ADDR_W'(issue_addr);
    end

    // Two-stage pipeline; clear kills whatever is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1 <= '0;
            stage2 <= '0;
        end else if (clear) begin
            stage1 <= '0;
            stage2 <= '0;
        end else begin
            stage1 <= stage1_d;
            stage2 <= stage1;
        end
    end

    assign acc_en    = stage1.acc_en;
    assign byte_sel  = stage1.byte_sel[BSEL_W-1:0];
    assign zero_sel  = stage1.acc_en & (stage1.byte_sel == '0);
    assign write_ram = stage2.close;
    assign ram_addr  = stage2.addr[ADDR_W-1:0];
    assign ram_full  = (state_q == FULL);

    // Stage records carry fields and upper bits that this configuration never reads.
    assign unused_stage_bits = ^{stage1, stage2};

endmodule

// File: tb/tb_word_pack_ctrl.sv
// Bench for word_pack_ctrl: a hold-on-full and a wrapping instance share stimulus.
// Latency: directed traces pin the 1-cycle accumulate and 2-cycle write timing.
// Backpressure: fifo_empty, flush, clear and reset are driven randomly afterwards.
module tb_word_pack_ctrl;

    localparam int BPW   = 4;
    localparam int DEPTH = 4;
    localparam int N     = 8192;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic       flush;
    logic       clear;
    logic       rd_o   [2];
    logic       acc_o  [2];
    logic       zs_o   [2];
    logic [1:0] bsel_o [2];
    logic       wr_o   [2];
    logic [1:0] addr_o [2];
    logic       full_o [2];

    always #5 clk = ~clk;

    word_pack_ctrl #(.BYTES_PER_WORD(BPW), .RAM_DEPTH(DEPTH), .WRAP(0)) dut_hold (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .flush(flush), .clear(clear),
        .read(rd_o[0]), .acc_en(acc_o[0]), .zero_sel(zs_o[0]), .byte_sel(bsel_o[0]),
        .write_ram(wr_o[0]), .ram_addr(addr_o[0]), .ram_full(full_o[0])
    );

    word_pack_ctrl #(.BYTES_PER_WORD(BPW), .RAM_DEPTH(DEPTH), .WRAP(1)) dut_wrap (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .flush(flush), .clear(clear),
        .read(rd_o[1]), .acc_en(acc_o[1]), .zero_sel(zs_o[1]), .byte_sel(bsel_o[1]),
        .write_ram(wr_o[1]), .ram_addr(addr_o[1]), .ram_full(full_o[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an event calendar indexed by cycle number. A pop at
    // cycle t books an accumulate at t+1; a closed word books a write at t+2.
    int  cyc = 0;
    bit  exp_acc  [2][N];
    int  exp_bsel [2][N];
    bit  exp_wr   [2][N];
    int  exp_addr [2][N];
    int  m_cnt    [2];
    int  m_addr   [2];
    bit  m_full   [2];
    bit  exp_rd;
    bit  closing;

    // Per-cycle compare of both instances against the model, then model advance.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                check($sformatf("rst read[%0d]", i),     int'(rd_o[i]),   0);
                check($sformatf("rst acc_en[%0d]", i),   int'(acc_o[i]),  0);
                check($sformatf("rst zero_sel[%0d]", i), int'(zs_o[i]),   0);
                check($sformatf("rst byte_sel[%0d]", i), int'(bsel_o[i]), 0);
                check($sformatf("rst write_ram[%0d]", i), int'(wr_o[i]),  0);
                check($sformatf("rst ram_addr[%0d]", i), int'(addr_o[i]), 0);
                check($sformatf("rst ram_full[%0d]", i), int'(full_o[i]), 0);
                m_cnt[i]  = 0;
                m_addr[i] = 0;
                m_full[i] = 1'b0;
                exp_acc[i][cyc+1] = 1'b0;
                exp_wr[i][cyc+1]  = 1'b0;
                exp_wr[i][cyc+2]  = 1'b0;
            end else begin
                exp_rd = !m_full[i] && !fifo_empty && !flush && !clear;
                check($sformatf("read[%0d]", i),   int'(rd_o[i]),  int'(exp_rd));
                check($sformatf("acc_en[%0d]", i), int'(acc_o[i]), int'(exp_acc[i][cyc]));
                if (exp_acc[i][cyc]) begin
                    check($sformatf("byte_sel[%0d]", i), int'(bsel_o[i]), exp_bsel[i][cyc]);
                    check($sformatf("zero_sel[%0d]", i), int'(zs_o[i]), int'(exp_bsel[i][cyc] == 0));
                end else begin
                    check($sformatf("idle zero_sel[%0d]", i), int'(zs_o[i]), 0);
                end
                check($sformatf("write_ram[%0d]", i), int'(wr_o[i]), int'(exp_wr[i][cyc]));
                if (exp_wr[i][cyc]) begin
                    check($sformatf("ram_addr[%0d]", i), int'(addr_o[i]), exp_addr[i][cyc]);
                end
                check($sformatf("ram_full[%0d]", i), int'(full_o[i]), int'(m_full[i]));

                if (clear) begin
                    m_cnt[i]  = 0;
                    m_addr[i] = 0;
                    m_full[i] = 1'b0;
                    exp_acc[i][cyc+1] = 1'b0;
                    exp_wr[i][cyc+1]  = 1'b0;
                    exp_wr[i][cyc+2]  = 1'b0;
                end else begin
                    closing = 1'b0;
                    if (exp_rd) begin
                        exp_acc[i][cyc+1]  = 1'b1;
                        exp_bsel[i][cyc+1] = m_cnt[i];
                        closing            = (m_cnt[i] == BPW - 1);
                        m_cnt[i]           = (m_cnt[i] + 1) % BPW;
                    end else if (!m_full[i] && flush && m_cnt[i] != 0) begin
                        closing  = 1'b1;
                        m_cnt[i] = 0;
                    end
                    if (closing) begin
                        exp_wr[i][cyc+2]   = 1'b1;
                        exp_addr[i][cyc+2] = m_addr[i];
                        if (m_addr[i] == DEPTH - 1) begin
                            if (i == 1) m_addr[i] = 0;
                            else        m_full[i] = 1'b1;
                        end else begin
                            m_addr[i] = m_addr[i] + 1;
                        end
                    end
                end
            end
        end
        cyc++;
    end

    // Short trace of outputs used by the directed, hand-computed checks.
    logic [63:0] tr_rd, tr_acc, tr_zs, tr_wr, tr_full, trb_wr, trb_full;
    int          tr_bsel [64];
    int          tr_addr [64];
    int          trb_addr[64];
    int          tr_n;

    task automatic trace_start();
        tr_n = 0;
        tr_rd = '0; tr_acc = '0; tr_zs = '0; tr_wr = '0; tr_full = '0;
        trb_wr = '0; trb_full = '0;
    endtask

    // One clock cycle: drive just after the edge, sample mid-cycle.
    task automatic step(input bit e, input bit f, input bit c, input bit r);
        @(posedge clk);
        #1;
        fifo_empty = e;
        flush      = f;
        clear      = c;
        reset      = r;
        #2;
        if (tr_n < 64) begin
            tr_rd[tr_n]    = rd_o[0];
            tr_acc[tr_n]   = acc_o[0];
            tr_zs[tr_n]    = zs_o[0];
            tr_wr[tr_n]    = wr_o[0];
            tr_full[tr_n]  = full_o[0];
            tr_bsel[tr_n]  = int'(bsel_o[0]);
            tr_addr[tr_n]  = int'(addr_o[0]);
            trb_wr[tr_n]   = wr_o[1];
            trb_full[tr_n] = full_o[1];
            trb_addr[tr_n] = int'(addr_o[1]);
            tr_n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t, limit 500000", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; fifo_empty = 1'b1; flush = 1'b0; clear = 1'b0;
        trace_start();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Continuous reads of eight bytes: two full words.
        step(1, 0, 1, 0);
        trace_start();
        for (int k = 0; k < 12; k++) step(k >= 8, 0, 0, 0);
        check("t1 read trace",  int'(tr_rd[11:0]),  'h0FF);
        check("t1 acc_en trace", int'(tr_acc[11:0]), 'h1FE);
        check("t1 zero_sel trace", int'(tr_zs[11:0]), 'h022);
        check("t1 write trace", int'(tr_wr[11:0]),  'h220);
        check("t1 addr@5", tr_addr[5], 0);
        check("t1 addr@9", tr_addr[9], 1);

        // FIFO empty every other cycle.
        step(1, 0, 1, 0);
        trace_start();
        for (int k = 0; k < 12; k++) step((k >= 8) ? 1'b1 : 1'(k % 2), 0, 0, 0);
        check("t2 read trace",  int'(tr_rd[11:0]),  'h055);
        check("t2 acc_en trace", int'(tr_acc[11:0]), 'h0AA);
        for (int j = 0; j < 4; j++) check($sformatf("t2 byte_sel #%0d", j), tr_bsel[2*j+1], j);
        check("t2 write trace", int'(tr_wr[11:0]),  'h100);
        check("t2 addr@8", tr_addr[8], 0);

        // Three bytes then flush; a second flush on an empty word does nothing.
        step(1, 0, 1, 0);
        trace_start();
        for (int k = 0; k < 12; k++)
            step(!(k <= 3 || k == 8), (k == 3 || k == 5), 0, 0);
        check("t3 read trace",  int'(tr_rd[11:0]),  'h107);
        check("t3 acc_en trace", int'(tr_acc[11:0]), 'h20E);
        check("t3 write trace", int'(tr_wr[11:0]),  'h020);
        check("t3 zero_sel trace", int'(tr_zs[11:0]), 'h202);
        check("t3 addr@5", tr_addr[5], 0);
        check("t3 byte_sel@3", tr_bsel[3], 2);
        check("t3 byte_sel@9", tr_bsel[9], 0);

        // Fill the hold-on-full instance, then clear and write again.
        step(1, 0, 1, 0);
        trace_start();
        for (int k = 0; k < 27; k++) step(0, 0, k == 20, 0);
        check("t4 write trace", int'(tr_wr[26:0]), 'h4022220);
        check("t4 read while full", int'(tr_rd[20:16]), 0);
        check("t4 ram_full before", int'(tr_full[15]), 0);
        check("t4 ram_full after", int'(tr_full[19]), 1);
        check("t4 ram_full cleared", int'(tr_full[21]), 0);
        check("t4 addr@5", tr_addr[5], 0);
        check("t4 addr@9", tr_addr[9], 1);
        check("t4 addr@13", tr_addr[13], 2);
        check("t4 addr@17", tr_addr[17], 3);
        check("t4 addr after clear", tr_addr[26], 0);

        // Five words on the wrapping instance.
        step(1, 0, 1, 0);
        trace_start();
        for (int k = 0; k < 24; k++) step(k >= 20, 0, 0, 0);
        check("t5 write trace", int'(trb_wr[23:0]), 'h222220);
        check("t5 ram_full never", int'(trb_full[23:0]), 0);
        for (int j = 0; j < 5; j++) check($sformatf("t5 addr #%0d", j), trb_addr[5 + 4*j], j % 4);

        // Clear right after the last-byte pop kills that word.
        step(1, 0, 1, 0);
        trace_start();
        for (int k = 0; k < 8; k++) step(0, 0, k == 4, 0);
        check("t6 write suppressed", int'(tr_wr[7:0]), 0);
        check("t6 acc_en trace", int'(tr_acc[7:0]), 'hDE);
        check("t6 zero_sel trace", int'(tr_zs[7:0]), 'h42);
        check("t6 byte_sel restart", tr_bsel[6], 0);
        check("t6 byte_sel next", tr_bsel[7], 1);

        // Reset mid-word, away from any clock edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("async rst acc_en[%0d]", i), int'(acc_o[i]), 0);
            check($sformatf("async rst read[%0d]", i),   int'(rd_o[i]),   0);
            check($sformatf("async rst byte_sel[%0d]", i), int'(bsel_o[i]), 0);
            check($sformatf("async rst write_ram[%0d]", i), int'(wr_o[i]), 0);
        end
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 299) == 0);
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
